// File: rtl/neuron_weight_sequencer_pkg.sv
// rtl/neuron_weight_sequencer_pkg.sv - shared types and defaults for the neuron weight sequencer
// Purpose: FSM state encoding and default sizing shared by the sequencer,
//          its bus interface and the bench.
// Ports:   none (package).
package neuron_pkg;

  localparam int WEIGHT_WIDTH_DEFAULT = 32;
  localparam int INPUT_NUM_DEFAULT    = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    LOADED,
    RUN
  } wseq_state_t;

endpackage

// File: rtl/neuron_weight_sequencer_if.sv
// rtl/neuron_weight_sequencer_if.sv - weight load stream, weight output stream and SRAM port bundle
// Purpose: groups the handshake streams and the SRAM control/data lines of
//          one neuron weight sequencer.
// Ports:   master modport = sequencer view (drives wr_ready, w_*, sram_* controls),
//          slave modport  = surrounding logic view (weight source, MAC, SRAM).
//          wr_valid/wr_data/wr_ready           : weight load stream
//          w_valid/w_ready/w_data/w_last       : weight output stream to the MAC
//          sram_read_enable/sram_read_address  : SRAM read port (combinational read)
//          sram_write_enable/_address/_data    : SRAM write port (synchronous write)
//          sram_read_data                      : SRAM read data
interface neuron_weight_sequencer_if
  import neuron_pkg::*;
#(
  parameter int WEIGHT_WIDTH = WEIGHT_WIDTH_DEFAULT,
  parameter int INPUT_NUM    = INPUT_NUM_DEFAULT
);

  logic                    wr_valid;
  logic [WEIGHT_WIDTH-1:0] wr_data;
  logic                    wr_ready;

  logic                    w_valid;
  logic                    w_ready;
  logic [WEIGHT_WIDTH-1:0] w_data;
  logic                    w_last;

  logic                    sram_read_enable;
  logic [INPUT_NUM-1:0]    sram_read_address;
  logic                    sram_write_enable;
  logic [INPUT_NUM-1:0]    sram_write_address;
  logic [WEIGHT_WIDTH-1:0] sram_write_data;
  logic [WEIGHT_WIDTH-1:0] sram_read_data;

  modport master (
    input  wr_valid, wr_data, w_ready, sram_read_data,
    output wr_ready, w_valid, w_data, w_last,
    output sram_read_enable, sram_read_address,
    output sram_write_enable, sram_write_address, sram_write_data
  );

  modport slave (
    output wr_valid, wr_data, w_ready, sram_read_data,
    input  wr_ready, w_valid, w_data, w_last,
    input  sram_read_enable, sram_read_address,
    input  sram_write_enable, sram_write_address, sram_write_data
  );

endinterface

// File: rtl/neuron_weight_sequencer.sv
// rtl/neuron_weight_sequencer.sv - load/replay controller for one neuron's weight SRAM
// Purpose: LOAD writes a stream of INPUT_NUM weights to SRAM addresses 0..INPUT_NUM-1;
//          RUN reads them back in address order and streams them to the MAC with
//          backpressure, a last flag and a one-cycle done pulse.
// Ports:   clk, rst (synchronous, active high)
//          load_start : pulse, begin (re)loading weights
//          start      : pulse, stream the stored weights
//          busy       : high in LOAD or RUN
//          loaded     : a complete weight set is stored
//          done       : one-cycle pulse after the last output handshake
//          bias_out   : stored bias word (only with NEURON_BIAS_LOAD_EN)
//          bus        : neuron_weight_sequencer_if.master (streams + SRAM port)
// Config:  NEURON_BIAS_LOAD_EN - LOAD takes one extra word after the weights and keeps
//          it in a register (never written to SRAM), presented on bias_out.
module neuron_weight_sequencer
  import neuron_pkg::*;
#(
  parameter int WEIGHT_WIDTH = WEIGHT_WIDTH_DEFAULT,
  parameter int INPUT_NUM    = INPUT_NUM_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_start,
  input  logic                    start,
  output logic                    busy,
  output logic                    loaded,
  output logic                    done,
`ifdef NEURON_BIAS_LOAD_EN
  output logic [WEIGHT_WIDTH-1:0] bias_out,
`endif
  neuron_weight_sequencer_if.master bus
);

  localparam int ADDR_W = $clog2(INPUT_NUM);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(INPUT_NUM - 1);

  wseq_state_t       state_q, state_d;
  logic [ADDR_W-1:0] wr_cnt_q, rd_cnt_q;
  logic              loaded_q, done_q;
  logic              wr_hs, w_hs;
  logic              rd_last;
  logic              weight_phase;   // current LOAD word goes to SRAM
  logic              load_complete;  // current LOAD word is the final one

`ifdef NEURON_BIAS_LOAD_EN
  // Set once all weights are in; the next accepted word is the bias. Keeps the
  // address counter inside 0..INPUT_NUM-1 instead of stretching it by one.
  logic                    bias_phase_q;
  logic [WEIGHT_WIDTH-1:0] bias_q;

  assign weight_phase  = !bias_phase_q;
  assign load_complete = bias_phase_q;
  assign bias_out      = bias_q;
`else
  assign weight_phase  = 1'b1;
  assign load_complete = (wr_cnt_q == LAST_IDX);
`endif

  assign rd_last = (rd_cnt_q == LAST_IDX);

  // Counters sit at 0 outside their phase, so the addresses idle at 0.
  assign bus.sram_write_address = {{(INPUT_NUM - ADDR_W){1'b0}}, wr_cnt_q};
  assign bus.sram_read_address  = {{(INPUT_NUM - ADDR_W){1'b0}}, rd_cnt_q};
  assign bus.sram_write_data    = bus.wr_data;
  assign bus.w_data             = bus.sram_read_data;

  assign busy   = (state_q == LOAD) || (state_q == RUN);
  assign loaded = loaded_q;
  assign done   = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake and enable outputs are masked by rst so an abort never lets a
  // write or an output transfer slip through in the reset cycle itself.
  always_comb begin
    state_d               = state_q;
    bus.wr_ready          = 1'b0;
    bus.w_valid           = 1'b0;
    bus.w_last            = 1'b0;
    bus.sram_read_enable  = 1'b0;
    bus.sram_write_enable = 1'b0;
    wr_hs                 = 1'b0;
    w_hs                  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start) state_d = LOAD;
      end
      LOAD: begin
        bus.wr_ready          = !rst;
        wr_hs                 = !rst && bus.wr_valid;
        bus.sram_write_enable = wr_hs && weight_phase;
        if (wr_hs && load_complete) state_d = LOADED;
      end
      LOADED: begin
        if (load_start)  state_d = LOAD;
        else if (start)  state_d = RUN;
      end
      RUN: begin
        bus.w_valid          = !rst;
        bus.sram_read_enable = !rst;
        bus.w_last           = !rst && rd_last;
        w_hs                 = !rst && bus.w_ready;
        if (w_hs && rd_last) state_d = LOADED;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      loaded_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef NEURON_BIAS_LOAD_EN
      bias_phase_q <= 1'b0;
      bias_q       <= '0;
`endif
    end else begin
      done_q <= w_hs && rd_last;

      if (wr_hs && weight_phase) begin
        wr_cnt_q <= (wr_cnt_q == LAST_IDX) ? '0 : wr_cnt_q + 1'b1;
      end

`ifdef NEURON_BIAS_LOAD_EN
      if (wr_hs) begin
        if (bias_phase_q) begin
          bias_q       <= bus.wr_data;
          bias_phase_q <= 1'b0;
        end else if (wr_cnt_q == LAST_IDX) begin
          bias_phase_q <= 1'b1;
        end
      end
`endif

      if (w_hs) begin
        rd_cnt_q <= rd_last ? '0 : rd_cnt_q + 1'b1;
      end

      if (state_q != LOAD && state_d == LOAD) begin
        loaded_q <= 1'b0;
      end else if (state_q == LOAD && state_d == LOADED) begin
        loaded_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_neuron_weight_sequencer.sv
// tb/tb_neuron_weight_sequencer.sv - self-checking bench for neuron_weight_sequencer
// Purpose: drives load and run phases with random data, valid gaps and backpressure,
//          models the SRAM, and checks against the stored reference weight set.
// Ports:   none (top-level bench). NEURON_BIAS_LOAD_EN enables the bias checks.
module tb_neuron_weight_sequencer;
  import neuron_pkg::*;

  localparam int WW = 32;
  localparam int N  = 8;
  localparam int AW = $clog2(N);
`ifdef NEURON_BIAS_LOAD_EN
  localparam int NWORDS = N + 1;
`else
  localparam int NWORDS = N;
`endif

  logic clk = 1'b0;
  logic rst, load_start, start;
  logic busy, loaded, done;
`ifdef NEURON_BIAS_LOAD_EN
  logic [WW-1:0] bias_out;
`endif

  int total = 0;
  int bad   = 0;

  neuron_weight_sequencer_if #(.WEIGHT_WIDTH(WW), .INPUT_NUM(N)) bus ();

  neuron_weight_sequencer #(.WEIGHT_WIDTH(WW), .INPUT_NUM(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .start      (start),
    .busy       (busy),
    .loaded     (loaded),
    .done       (done),
`ifdef NEURON_BIAS_LOAD_EN
    .bias_out   (bias_out),
`endif
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // SRAM model: synchronous write, combinational read.
  logic [WW-1:0] mem [N];
  int write_count = 0;
  always @(posedge clk) begin
    if (bus.sram_write_enable) begin
      mem[bus.sram_write_address[AW-1:0]] <= bus.sram_write_data;
      write_count <= write_count + 1;
    end
  end
  assign bus.sram_read_data = mem[bus.sram_read_address[AW-1:0]];

  logic [WW-1:0] stim  [NWORDS];
  logic [WW-1:0] ref_w [N];

  // Leaves the bench at the first negedge with the DUT in LOAD.
  task automatic pulse_load();
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // Entered at a negedge with the DUT in LOAD; feeds stim[].
  task automatic load_words(input int valid_pct, input string tag);
    int i = 0;
    int cycles = 0;
    int wc0 = write_count;
    while (i < NWORDS && cycles < 200) begin
      bus.wr_valid = ($urandom_range(99) < valid_pct);
      bus.wr_data  = bus.wr_valid ? stim[i] : $urandom();
      start        = ($urandom_range(9) == 0);
      load_start   = ($urandom_range(9) == 0);
      #1;
      total++;
      if ({bus.wr_ready, busy, loaded, bus.sram_write_enable} !== {3'b110, bus.wr_valid && (i < N)}) begin
        bad++;
        $display("FAIL %s load_ctl word=%0d got=%b exp=%b", tag, i,
                 {bus.wr_ready, busy, loaded, bus.sram_write_enable}, {3'b110, bus.wr_valid && (i < N)});
      end
      if (bus.wr_valid && i < N) begin
        total++;
        if ({bus.sram_write_address, bus.sram_write_data} !== {N'(i), stim[i]}) begin
          bad++;
          $display("FAIL %s write_port word=%0d got=%h/%h exp=%h/%h", tag, i,
                   bus.sram_write_address, bus.sram_write_data, N'(i), stim[i]);
        end
      end
      @(posedge clk);
      if (bus.wr_valid) i++;
      @(negedge clk);
      cycles++;
    end
    bus.wr_valid = 1'b0;
    start        = 1'b0;
    load_start   = 1'b0;
    total++;
    if (i != NWORDS) begin
      bad++;
      $display("FAIL %s load_timeout got=%0d words exp=%0d", tag, i, NWORDS);
    end
    if (valid_pct >= 100) begin
      total++;
      if (cycles != NWORDS) begin
        bad++;
        $display("FAIL %s load_cycles got=%0d exp=%0d", tag, cycles, NWORDS);
      end
    end
    for (int k = 0; k < N; k++) ref_w[k] = stim[k];
    #1;
    total++;
    if ({loaded, busy, bus.wr_ready, bus.sram_write_enable} !== 4'b1000) begin
      bad++;
      $display("FAIL %s loaded_state got=%b exp=1000", tag, {loaded, busy, bus.wr_ready, bus.sram_write_enable});
    end
    total++;
    if (write_count - wc0 != N) begin
      bad++;
      $display("FAIL %s write_count got=%0d exp=%0d", tag, write_count - wc0, N);
    end
    for (int k = 0; k < N; k++) begin
      total++;
      if (mem[k] !== ref_w[k]) begin
        bad++;
        $display("FAIL %s sram_content addr=%0d got=%h exp=%h", tag, k, mem[k], ref_w[k]);
      end
    end
`ifdef NEURON_BIAS_LOAD_EN
    total++;
    if (bias_out !== stim[N]) begin
      bad++;
      $display("FAIL %s bias_out got=%h exp=%h", tag, bias_out, stim[N]);
    end
`endif
  endtask

  // mode 0: always ready, 1: ready low 2 cycles at index 3, 2: random backpressure.
  task automatic run_weights(input int mode, input string tag);
    int k = 0;
    int cycles = 0;
    int stall = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (k < N && cycles < 300) begin
      case (mode)
        0: bus.w_ready = 1'b1;
        1: begin
          if (k == 3 && stall < 2) begin
            bus.w_ready = 1'b0;
            stall++;
          end else begin
            bus.w_ready = 1'b1;
          end
        end
        default: bus.w_ready = ($urandom_range(99) < 60);
      endcase
      start      = ($urandom_range(9) == 0);
      load_start = ($urandom_range(9) == 0);
      #1;
      total++;
      if ({bus.w_valid, bus.sram_read_enable, busy, done, bus.w_last} !== {4'b1110, k == N - 1}) begin
        bad++;
        $display("FAIL %s run_ctl idx=%0d got=%b exp=%b", tag, k,
                 {bus.w_valid, bus.sram_read_enable, busy, done, bus.w_last}, {4'b1110, k == N - 1});
      end
      total++;
      if ({bus.w_data, bus.sram_read_address} !== {ref_w[k], N'(k)}) begin
        bad++;
        $display("FAIL %s run_data idx=%0d got=%h/%h exp=%h/%h", tag, k,
                 bus.w_data, bus.sram_read_address, ref_w[k], N'(k));
      end
`ifdef NEURON_BIAS_LOAD_EN
      total++;
      if (bias_out !== stim[N]) begin
        bad++;
        $display("FAIL %s bias_stable got=%h exp=%h", tag, bias_out, stim[N]);
      end
`endif
      @(posedge clk);
      if (bus.w_ready) k++;
      @(negedge clk);
      cycles++;
    end
    bus.w_ready = 1'b0;
    start       = 1'b0;
    load_start  = 1'b0;
    total++;
    if (k != N) begin
      bad++;
      $display("FAIL %s run_timeout got=%0d exp=%0d", tag, k, N);
    end
    if (mode < 2) begin
      total++;
      if (cycles != N + 2 * mode) begin
        bad++;
        $display("FAIL %s run_cycles got=%0d exp=%0d", tag, cycles, N + 2 * mode);
      end
    end
    #1;
    total++;
    if ({done, bus.w_valid, bus.sram_read_enable, busy, loaded} !== 5'b10001) begin
      bad++;
      $display("FAIL %s done_pulse got=%b exp=10001", tag, {done, bus.w_valid, bus.sram_read_enable, busy, loaded});
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL %s done_width got=%b exp=0", tag, done);
    end
  endtask

  task automatic check_all_zero(input string tag);
    logic [2*N+7:0] outs;
    outs = {busy, loaded, done, bus.wr_ready, bus.w_valid, bus.w_last,
            bus.sram_read_enable, bus.sram_write_enable,
            bus.sram_read_address, bus.sram_write_address};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL %s outputs_zero got=%h exp=0", tag, outs);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
  endtask

  task automatic test_start_in_idle();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      #1;
      check_all_zero("start_in_idle");
      @(negedge clk);
    end
  endtask

  task automatic test_load_basic();
    for (int k = 0; k < N; k++) stim[k] = WW'(32'h11 + k);
`ifdef NEURON_BIAS_LOAD_EN
    stim[N] = 32'hB1;
`endif
    pulse_load();
    load_words(100, "load_basic");
  endtask

  task automatic test_both_pulses();
    @(negedge clk);
    start      = 1'b1;
    load_start = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    load_start = 1'b0;
    #1;
    total++;
    if ({bus.wr_ready, busy, loaded, bus.w_valid} !== 4'b1100) begin
      bad++;
      $display("FAIL both_pulses got=%b exp=1100", {bus.wr_ready, busy, loaded, bus.w_valid});
    end
    for (int k = 0; k < NWORDS; k++) stim[k] = $urandom();
    load_words(50, "both_pulses");
    run_weights(2, "both_pulses_run");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NWORDS; k++) stim[k] = $urandom();
      pulse_load();
      load_words(70, "random_load");
      run_weights(2, "random_run");
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bus.w_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({bus.w_valid, bus.sram_read_enable} !== 2'b00) begin
      bad++;
      $display("FAIL reset_mid_run abort got=%b exp=00", {bus.w_valid, bus.sram_read_enable});
    end
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset_mid_run");
    rst = 1'b0;
    bus.w_ready = 1'b0;
    test_start_in_idle();
  endtask

  task automatic test_reset_mid_load();
    int wc0;
    for (int k = 0; k < NWORDS; k++) stim[k] = $urandom();
    pulse_load();
    wc0 = write_count;
    for (int k = 0; k < 3; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = stim[k];
      @(negedge clk);
    end
    rst = 1'b1;
    bus.wr_data = stim[3];
    #1;
    total++;
    if (bus.sram_write_enable !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_load write_enable got=%b exp=0", bus.sram_write_enable);
    end
    @(negedge clk);
    bus.wr_valid = 1'b0;
    #1;
    total++;
    if ({write_count - wc0, mem[3]} !== {3, ref_w[3]}) begin
      bad++;
      $display("FAIL reset_mid_load sram got=%0d/%h exp=3/%h", write_count - wc0, mem[3], ref_w[3]);
    end
    check_all_zero("reset_mid_load");
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    load_start   = 1'b0;
    start        = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.w_ready  = 1'b0;
    test_reset();
    test_start_in_idle();
    test_load_basic();
    run_weights(0, "run_basic");
    run_weights(1, "run_stall");
    test_both_pulses();
    test_random();
    test_reset_mid_run();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
